// File: rtl/data_sram_resp_pkg.sv
// Shared constants and request type for the data-SRAM responder.
// Lane geometry, latency bound, write-enable decode and stall encoding.
package data_sram_resp_pkg;

  localparam int DATA_W          = 32;
  localparam int NUM_LANES       = 4;
  localparam int LANE_W          = 8;
  localparam int MAX_RAM_LATENCY = 4;
  localparam int CNT_W           = $clog2(MAX_RAM_LATENCY);

  localparam logic [NUM_LANES-1:0] WEN_READ = 4'b0000;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  typedef struct packed {
    logic                  en;
    logic [NUM_LANES-1:0]  wen;
    logic [31:0]           addr;
    logic [DATA_W-1:0]     wdata;
  } sram_req_t;

  function automatic logic is_read(input logic [NUM_LANES-1:0] wen);
    return wen == WEN_READ;
  endfunction

endpackage

// File: rtl/data_ram_byte_lane.sv
// One byte column of the data RAM: synchronous write, asynchronous read.
// The responder registers the read result, so no output register lives here.
module data_ram_byte_lane
  import data_sram_resp_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [LANE_W-1:0]     wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [LANE_W-1:0]     rdata
);

  logic [LANE_W-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/data_sram_resp.sv
// Responder end of the CPU data-SRAM port: byte-writable word RAM with a
// configurable read latency and a stall request while a slow read is pending.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 data_sram_en,
  input  logic [NUM_LANES-1:0] data_sram_wen,
  input  logic [31:0]          data_sram_addr,
  input  logic [DATA_W-1:0]    data_sram_wdata,
  output logic [DATA_W-1:0]    data_sram_rdata,
  output logic                 rdata_valid,
  output logic                 stallreq
);

  if (LATENCY < 1 || LATENCY > MAX_RAM_LATENCY) begin : g_bad_latency
    $error("data_sram_resp: LATENCY %0d outside 1..%0d", LATENCY, MAX_RAM_LATENCY);
  end

  sram_req_t req;
  assign req = '{en: data_sram_en, wen: data_sram_wen,
                 addr: data_sram_addr, wdata: data_sram_wdata};

  logic [0:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic [ADDR_WIDTH-1:0] word, idx_q, raddr;
  logic                  accept, wr, rd_acc;
  logic                  unused_addr_bits;

  // Upper and sub-word address bits are dropped: addresses alias modulo depth.
  assign word             = req.addr[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^{req.addr[31:ADDR_WIDTH+2], req.addr[1:0]};

  assign accept = req.en && (state == S_IDLE);
  assign wr     = accept && !is_read(req.wen) && !rst;
  assign rd_acc = accept && is_read(req.wen);
  assign raddr  = (state == S_WAIT) ? idx_q : word;

  logic [NUM_LANES-1:0][LANE_W-1:0] lane_wdata, lane_rdata;
  assign lane_wdata = req.wdata;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    data_ram_byte_lane #(.ADDR_WIDTH(ADDR_WIDTH)) u_lane (
      .clk   (clk),
      .we    (wr && req.wen[g]),
      .waddr (word),
      .wdata (lane_wdata[g]),
      .raddr (raddr),
      .rdata (lane_rdata[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      cnt             <= '0;
      idx_q           <= '0;
      data_sram_rdata <= '0;
      rdata_valid     <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rd_acc) begin
            if (LATENCY == 1) begin
              data_sram_rdata <= lane_rdata;
              rdata_valid     <= 1'b1;
            end else begin
              idx_q <= word;
              cnt   <= CNT_W'(LATENCY - 1);
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // Memory is read through the latched index, so requests seen while
          // waiting cannot disturb the outstanding read.
          if (cnt == CNT_W'(1)) begin
            data_sram_rdata <= lane_rdata;
            rdata_valid     <= 1'b1;
            cnt             <= '0;
            state           <= S_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign stallreq = (state == S_WAIT) ? STOP : NO_STOP;

endmodule

// File: tb/tb_data_sram_resp.sv
// Three responders (latency 1, 3, 4) share one stimulus stream; each is
// compared every cycle against a word-level memory model plus directed checks.
module tb_data_sram_resp;

  localparam int NDUT = 3;

  logic                       clk = 1'b0;
  logic                       rst, en;
  logic [3:0]                 wen;
  logic [31:0]                addr, wdata;
  logic [NDUT-1:0][31:0]      rd;
  logic [NDUT-1:0]            vld, stl;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  data_sram_resp #(.ADDR_WIDTH(12), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .data_sram_en(en), .data_sram_wen(wen),
    .data_sram_addr(addr), .data_sram_wdata(wdata),
    .data_sram_rdata(rd[0]), .rdata_valid(vld[0]), .stallreq(stl[0]));

  data_sram_resp #(.ADDR_WIDTH(12), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .data_sram_en(en), .data_sram_wen(wen),
    .data_sram_addr(addr), .data_sram_wdata(wdata),
    .data_sram_rdata(rd[1]), .rdata_valid(vld[1]), .stallreq(stl[1]));

  data_sram_resp #(.ADDR_WIDTH(12), .LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst), .data_sram_en(en), .data_sram_wen(wen),
    .data_sram_addr(addr), .data_sram_wdata(wdata),
    .data_sram_rdata(rd[2]), .rdata_valid(vld[2]), .stallreq(stl[2]));

  function automatic int lat_of(int k);
    case (k)
      0:       return 1;
      1:       return 3;
      default: return 4;
    endcase
  endfunction

  // Reference: per-DUT word memory, cycles left until a pending read returns.
  logic [31:0] mm    [NDUT][4096];
  logic [31:0] m_rd  [NDUT];
  logic        m_vld [NDUT];
  int          m_left[NDUT];
  logic [11:0] m_idx [NDUT];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic model_edge(input logic r, e, input logic [3:0] w,
                            input logic [31:0] a, d);
    logic [11:0] wi;
    wi = a[13:2];
    for (int k = 0; k < NDUT; k++) begin
      if (r) begin
        m_rd[k] = '0; m_vld[k] = 1'b0; m_left[k] = 0;
      end else begin
        m_vld[k] = 1'b0;
        if (m_left[k] > 0) begin
          m_left[k]--;
          if (m_left[k] == 0) begin
            m_rd[k] = mm[k][m_idx[k]]; m_vld[k] = 1'b1;
          end
        end else if (e) begin
          if (w != 4'b0000) begin
            for (int b = 0; b < 4; b++)
              if (w[b]) mm[k][wi][8*b +: 8] = d[8*b +: 8];
          end else if (lat_of(k) == 1) begin
            m_rd[k] = mm[k][wi]; m_vld[k] = 1'b1;
          end else begin
            m_idx[k] = wi; m_left[k] = lat_of(k) - 1;
          end
        end
      end
    end
  endtask

  task automatic cyc(input logic r, e, input logic [3:0] w,
                     input logic [31:0] a, d);
    rst = r; en = e; wen = w; addr = a; wdata = d;
    @(posedge clk);
    model_edge(r, e, w, a, d);
    #1;
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("rdata_l%0d", lat_of(k)), rd[k], m_rd[k]);
      chk($sformatf("valid_l%0d", lat_of(k)), 32'(vld[k]), 32'(m_vld[k]));
      chk($sformatf("stall_l%0d", lat_of(k)), 32'(stl[k]), 32'(m_left[k] > 0));
    end
  endtask

  task automatic wr_word(input logic [31:0] a, d, input logic [3:0] w = 4'hF);
    cyc(1'b0, 1'b1, w, a, d);
  endtask

  task automatic rd_word(input logic [31:0] a);
    cyc(1'b0, 1'b1, 4'h0, a, $urandom());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'($urandom()), $urandom(), $urandom());
  endtask

  function automatic logic [11:0] pool_word(int i);
    return (i < 16) ? 12'(i) : 12'(4064 + i);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog no_finish got 0 exp 1");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < NDUT; k++) begin
      m_rd[k] = '0; m_vld[k] = 1'b0; m_left[k] = 0; m_idx[k] = '0;
    end

    cyc(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    cyc(1'b1, 1'b1, 4'h0, 32'h10, 32'h0);
    for (int k = 0; k < NDUT; k++) begin
      chk("reset_rdata", rd[k], 32'h0);
      chk("reset_valid", 32'(vld[k]), 32'h0);
      chk("reset_stall", 32'(stl[k]), 32'h0);
    end

    // Give every word the random phase can touch a defined value.
    for (int i = 0; i < 32; i++) wr_word({18'h0, pool_word(i), 2'b00}, $urandom());

    // Write then read back, latency 1.
    wr_word(32'h0000_0010, 32'hDEAD_BEEF);
    rd_word(32'h0000_0010);
    chk("t1_rdata", rd[0], 32'hDEAD_BEEF);
    chk("t1_valid", 32'(vld[0]), 32'h1);
    idle(5);

    // Byte-lane merge; sub-word address bits ignored on the read.
    wr_word(32'h0000_0020, 32'h1122_3344);
    wr_word(32'h0000_0020, 32'h0000_AA00, 4'b0010);
    rd_word(32'h0000_0023);
    chk("t2_merge", rd[0], 32'h1122_AA44);
    idle(5);

    // Latency 3: two stall cycles, write during WAIT is dropped.
    wr_word(32'h0000_0010, 32'hCAFE_F00D);
    rd_word(32'h0000_0010);
    chk("t3_stall1", 32'(stl[1]), 32'h1);
    wr_word(32'h0000_0010, 32'h0);
    chk("t3_stall2", 32'(stl[1]), 32'h1);
    idle(1);
    chk("t3_stall_end", 32'(stl[1]), 32'h0);
    chk("t3_valid", 32'(vld[1]), 32'h1);
    chk("t3_rdata", rd[1], 32'hCAFE_F00D);
    idle(3);
    rd_word(32'h0000_0010);
    idle(2);
    chk("t3_kept", rd[1], 32'hCAFE_F00D);
    idle(5);

    // Upper address bits alias.
    wr_word(32'h0000_4004, 32'h5A5A_5A5A);
    rd_word(32'h0000_0004);
    chk("t4_wrap", rd[0], 32'h5A5A_5A5A);
    idle(5);

    // Reset two cycles into a latency-4 read.
    rd_word(32'h0000_0020);
    idle(1);
    cyc(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("t5_stall", 32'(stl[2]), 32'h0);
    chk("t5_rdata", rd[2], 32'h0);
    chk("t5_valid", 32'(vld[2]), 32'h0);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("t5_no_pulse", 32'(vld[2]), 32'h0);
    end
    rd_word(32'h0000_0020);
    idle(3);
    chk("t5_persist", rd[2], 32'h1122_AA44);
    idle(5);

    // Reset wins over a coincident write.
    wr_word(32'h0000_0030, 32'h1234_5678);
    cyc(1'b1, 1'b1, 4'hF, 32'h0000_0030, 32'hFFFF_FFFF);
    rd_word(32'h0000_0030);
    chk("t6_rst_prio", rd[0], 32'h1234_5678);
    idle(5);

    for (int n = 0; n < 3000; n++) begin
      logic        r, e;
      logic [3:0]  w;
      logic [31:0] a;
      r = ($urandom_range(0, 49) == 0);
      e = ($urandom_range(0, 9) < 7);
      w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      a = ($urandom() << 14) | (32'(pool_word($urandom_range(0, 31))) << 2)
          | 32'($urandom_range(0, 3));
      cyc(r, e, w, a, $urandom());
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/data_sram_resp.md
Name: data_sram_resp

Overview:
- Responder (slave) end of the CPU data-SRAM interface: accepts en/wen/addr/wdata requests issued from EX and returns data_sram_rdata to the MEM stage.
- Word-organised, byte-writable RAM with configurable read latency.
- When latency exceeds one cycle, asserts a stall request toward the pipeline stall controller.
- Used as the data memory in simulation and FPGA builds.

Parameters:
- ADDR_WIDTH, 12, word-address bits; depth is 2**ADDR_WIDTH 32-bit words.
- LATENCY, 1, read latency in cycles, counted from the request-accept edge to rdata valid; legal range 1..4.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- data_sram_en  in  1  request strobe.
- data_sram_wen  in  4  byte write enables; bit i writes wdata[8i+7:8i]; 4'b0000 means read.
- data_sram_addr  in  32  byte address.
- data_sram_wdata  in  32  write data.
- data_sram_rdata  out  32  read data.
- rdata_valid  out  1  one-cycle pulse; data_sram_rdata holds the result of the last read.
- stallreq  out  1  to the stall controller; high while a multi-cycle read is outstanding.

Behaviour:
- Word index = data_sram_addr[ADDR_WIDTH+1:2].
  - addr[1:0] ignored; no misalignment error.
  - Upper address bits ignored, so addresses alias/wrap modulo depth.
- Accept condition: data_sram_en && state==IDLE. Requests presented while busy are ignored; the pipeline is stalled then, so the request is re-presented.
- Write (accepted, wen!=0):
  - Enabled byte lanes update at the accept edge.
  - Zero latency cost: state stays IDLE, stallreq stays 0.
  - data_sram_rdata holds its previous value; rdata_valid=0.
- Read (accepted, wen==0), LATENCY=1:
  - data_sram_rdata = mem[word] is registered at the accept edge, so it is visible in the following cycle (MEM stage).
  - rdata_valid pulses in that cycle.
  - stallreq never asserts.
- Read, LATENCY=N>1:
  - At the accept edge, latch the word index and go to WAIT with cnt=N-1.
  - stallreq=1 combinationally in every WAIT cycle.
  - cnt decrements each cycle.
  - On the edge where cnt==1, register mem[latched index] into rdata, pulse rdata_valid, and return to IDLE.
  - Total: rdata visible N cycles after the accept edge; stallreq high for exactly N-1 cycles.
- Read-after-write, same word, back-to-back cycles: the read returns the newly written bytes. No bypass logic is needed because memory is updated at the earlier edge.
- Write and read to the same word are never simultaneous, since there is one request per cycle.
- State machine:
  - IDLE -> WAIT on an accepted read when LATENCY>1.
  - WAIT -> IDLE when cnt==1.
  - All other cases hold state.
- Reset (synchronous):
  - data_sram_rdata=0, rdata_valid=0, stallreq=0, state=IDLE, cnt=0.
  - Memory contents are not cleared.
- Reset mid-read: the pending read is aborted; no rdata_valid pulse follows. Writes committed before reset persist.
- rst has priority over any request in the same cycle; a write presented together with rst is not performed.
- LATENCY outside 1..4 is a configuration error; elaboration-time check/$error.

Decomposition:
- Add to lib/defines.vh:
  - `DataRamAddrBus width macro.
  - `MaxRamLatency 4.
  - Read/write decode constants: `WenRead 4'b0000.
  - Reuse the existing `Stop/`NoStop for stallreq.
- Sub-module data_ram_byte_lane: an 8-bit x depth synchronous array with a single write enable, instantiated 4 times.
- Control FSM, counter, and rdata register live in data_sram_resp.

Test Plan:
1. LATENCY=1:
   - Write addr 0x0000_0010, wen 4'b1111, wdata 0xDEADBEEF; next cycle read addr 0x10.
   - Expect: the cycle after the read, rdata=0xDEADBEEF, rdata_valid=1, stallreq never 1.
2. Byte lanes:
   - Write 0x11223344 full word to addr 0x20; then wen 4'b0010, wdata 0x0000AA00; then read 0x23 (low bits ignored).
   - Expect: rdata=0x1122AA44.
3. LATENCY=3:
   - Read addr 0x10 holding 0xCAFEF00D.
   - Expect: stallreq=1 for exactly 2 cycles after the accept edge; rdata=0xCAFEF00D with rdata_valid the 3rd cycle after acceptance.
   - A request presented during WAIT (write 0x10 <- 0) is ignored; memory still reads 0xCAFEF00D afterwards.
4. Wrap, ADDR_WIDTH=12:
   - Write 0x5A5A5A5A at addr 0x0000_4004.
   - Expect: reading addr 0x4 returns 0x5A5A5A5A.
5. Reset mid-read, LATENCY=4:
   - Assert rst 2 cycles after read accept.
   - Expect: next cycle stallreq=0, rdata=0, no rdata_valid pulse.
   - Earlier-written data is still readable after rst deasserts.
6. Reset priority:
   - rst=1 together with write 0xFFFFFFFF to addr 0x30 (previously 0x12345678).
   - Expect: a subsequent read returns 0x12345678.
